// File: rtl/tx_segment_replay_buffer_pkg.sv
// Shared encodings and sizing helpers for the TX segment replay buffer.
package tx_segment_replay_buffer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_FETCH  = 2'd1;
    localparam state_t ST_REPLAY = 2'd2;

    // Address width that never collapses to zero bits for tiny depths.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_segment_replay_buffer_segment_store_ram.sv
// Byte-wide simple dual-port RAM holding every segment's payload for replay.
module segment_store_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk125MHz,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk125MHz) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/tx_segment_replay_buffer.sv
// Ethernet TX payload source: streams VRAM pixels on a segment's first copy, records
// them, and replays the recorded bytes for the redundant copies.
module tx_segment_replay_buffer
    import tx_segment_replay_buffer_pkg::*;
#(
    parameter int BPP           = 3,
    parameter int FRAME_PIXELS  = 57600,
    parameter int ADDR_W        = 16,
    parameter int SEG_MAX       = 125,
    parameter int PAYLOAD_START = 46,
    parameter int PAYLOAD_BYTES = 1437,
    parameter int VRAM_LAT      = 2
) (
    input  logic              clk125MHz,
    input  logic              rst,
    input  logic [7:0]        txid,
    input  logic [15:0]       segment_num,
    input  logic [7:0]        redundancy,
    input  logic [15:0]       segment_num_max,
    input  logic [11:0]       byte_data_counter,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [BPP*8-1:0]  vram_rdata,
    output logic [7:0]        doutb,
    output logic [ADDR_W-1:0] startaddr,
    output logic              oneframe_done,
    output logic              maxdetect,
    output logic              seg_miss,
    output logic              seg_err
);
    localparam int RAM_DEPTH = SEG_MAX * PAYLOAD_BYTES;
    localparam int RAM_AW    = clog2_min1(RAM_DEPTH);
    localparam int SEG_W     = clog2_min1(SEG_MAX);
    localparam int PH_W      = clog2_min1(BPP);
    localparam int LEAD      = VRAM_LAT + 1;
    localparam logic [11:0] ISSUE_FIRST = 12'(PAYLOAD_START + 1 - LEAD);
    localparam logic [11:0] ISSUE_LAST  = 12'(PAYLOAD_START + PAYLOAD_BYTES - LEAD);
    localparam logic [11:0] OUT_FIRST   = 12'(PAYLOAD_START);
    localparam logic [11:0] OUT_LAST    = 12'(PAYLOAD_START + PAYLOAD_BYTES - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(BPP - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);

    if (PAYLOAD_BYTES % BPP != 0) begin : g_bad_payload
        $error("PAYLOAD_BYTES must be a multiple of BPP");
    end
    if (PAYLOAD_START < VRAM_LAT + 3) begin : g_bad_start
        $error("PAYLOAD_START too small for the VRAM read lead");
    end

    state_t            state;
    logic [7:0]        txid_q;
    logic [15:0]       seg_q;
    logic [11:0]       cnt_exp;
    logic [SEG_MAX-1:0] valid;
    logic              frame_over;
    logic [ADDR_W-1:0] start_table [SEG_MAX];
    logic [PH_W-1:0]   iss_ph, out_ph;
    logic [SEG_W-1:0]  seg_idx, new_idx;
    logic [RAM_AW-1:0] seg_base, ram_waddr, ram_raddr;
    logic [7:0]        pix_byte, ram_rdata;
    logic              active, in_issue, in_out, ram_we, rep_done;

    assign seg_idx  = seg_q[SEG_W-1:0];
    assign new_idx  = segment_num[SEG_W-1:0];
    // A counter that skips (other than restarting at 0) abandons the packet.
    assign active   = (state != ST_IDLE) && (byte_data_counter != 12'd0)
                      && (byte_data_counter == cnt_exp);
    assign in_issue = (byte_data_counter >= ISSUE_FIRST) && (byte_data_counter <= ISSUE_LAST);
    assign in_out   = (byte_data_counter >= OUT_FIRST) && (byte_data_counter <= OUT_LAST);
    assign pix_byte = 8'(vram_rdata >> (8 * (BPP - 1 - int'(out_ph))));
    assign seg_base = RAM_AW'(seg_idx) * RAM_AW'(PAYLOAD_BYTES);
    assign ram_waddr = seg_base + RAM_AW'(byte_data_counter - OUT_FIRST);
    // Read one byte early to absorb the RAM's registered read.
    assign ram_raddr = seg_base + RAM_AW'(byte_data_counter - OUT_FIRST + 12'd1);
    assign ram_we    = active && (state == ST_FETCH) && in_out;
    assign rep_done  = active && (state == ST_REPLAY) && (byte_data_counter == OUT_LAST)
                       && frame_over && (txid_q == redundancy)
                       && (seg_q == segment_num_max - 16'd1);
    assign maxdetect = (txid_q == 8'd1) && (vram_addr == ADDR_LAST);

    segment_store_ram #(.DEPTH(RAM_DEPTH), .AW(RAM_AW)) u_ram (
        .clk125MHz (clk125MHz),
        .we        (ram_we),
        .waddr     (ram_waddr),
        .wdata     (pix_byte),
        .raddr     (ram_raddr),
        .rdata     (ram_rdata)
    );

    always_ff @(posedge clk125MHz)
        if (!rst && active && (state == ST_FETCH) && (byte_data_counter == 12'd1))
            start_table[seg_idx] <= vram_addr;

    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            state         <= ST_IDLE;
            txid_q        <= '0;
            seg_q         <= '0;
            cnt_exp       <= '0;
            valid         <= '0;
            frame_over    <= 1'b0;
            iss_ph        <= '0;
            out_ph        <= '0;
            vram_addr     <= '0;
            doutb         <= '0;
            startaddr     <= '0;
            oneframe_done <= 1'b0;
            seg_miss      <= 1'b0;
            seg_err       <= 1'b0;
        end else begin
            oneframe_done <= 1'b0;
            seg_miss      <= 1'b0;
            doutb         <= '0;
            cnt_exp       <= byte_data_counter + 12'd1;
            if (byte_data_counter == 12'd0) begin
                txid_q <= txid;
                seg_q  <= segment_num;
                iss_ph <= '0;
                out_ph <= '0;
                if (segment_num >= 16'(SEG_MAX)) begin
                    state   <= ST_IDLE;
                    seg_err <= 1'b1;
                end else if (txid == 8'd1) begin
                    state          <= ST_FETCH;
                    valid[new_idx] <= 1'b0;
                end else if (valid[new_idx]) begin
                    state <= ST_REPLAY;
                end else begin
                    state    <= ST_IDLE;
                    seg_miss <= 1'b1;
                end
            end else if (!active) begin
                state <= ST_IDLE;
            end else begin
                if (byte_data_counter == 12'd1)
                    startaddr <= (state == ST_FETCH) ? vram_addr : start_table[seg_idx];
                if ((state == ST_FETCH) && in_issue) begin
                    iss_ph <= (iss_ph == PH_LAST) ? '0 : iss_ph + PH_W'(1);
                    if (iss_ph == PH_LAST) begin
                        if (vram_addr == ADDR_LAST) begin
                            vram_addr <= '0;
                            if (redundancy == 8'd1) begin
                                oneframe_done <= 1'b1;
                                valid         <= '0;
                                frame_over    <= 1'b0;
                            end else begin
                                frame_over <= 1'b1;
                            end
                        end else begin
                            vram_addr <= vram_addr + ADDR_W'(1);
                        end
                    end
                end
                if (in_out) begin
                    out_ph <= (out_ph == PH_LAST) ? '0 : out_ph + PH_W'(1);
                    doutb  <= (state == ST_FETCH) ? pix_byte : ram_rdata;
                end
                if (byte_data_counter == OUT_LAST) begin
                    state <= ST_IDLE;
                    if (state == ST_FETCH)
                        valid[seg_idx] <= 1'b1;
                    if (rep_done) begin
                        oneframe_done <= 1'b1;
                        valid         <= '0;
                        frame_over    <= 1'b0;
                        vram_addr     <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_segment_replay_buffer.sv
// Randomized bench for tx_segment_replay_buffer against a packet-level reference model.
module tb_tx_segment_replay_buffer;
    localparam int BPP     = 3;
    localparam int FP      = 1000;
    localparam int ADDR_W  = 16;
    localparam int SEG_MAX = 16;
    localparam int PS      = 46;
    localparam int PB      = 1437;
    localparam int VL      = 2;
    localparam int NP      = PB / BPP;
    localparam int PKT_LEN = PS + PB + 4;

    logic              clk125MHz = 1'b0;
    logic              rst;
    logic [7:0]        txid;
    logic [15:0]       segment_num;
    logic [7:0]        redundancy;
    logic [15:0]       segment_num_max;
    logic [11:0]       byte_data_counter;
    logic [ADDR_W-1:0] vram_addr;
    logic [23:0]       vram_rdata;
    logic [7:0]        doutb;
    logic [ADDR_W-1:0] startaddr;
    logic              oneframe_done, maxdetect, seg_miss, seg_err;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: frame pointer, per-segment recordings and flags.
    int               m_ptr;
    int               m_start;
    bit               m_fo;
    bit               m_err;
    bit [SEG_MAX-1:0] m_valid;
    int               m_start_tab [SEG_MAX];
    logic [7:0]       m_store [SEG_MAX][PB];
    logic [7:0]       seed;
    logic [23:0]      vq [VL];

    always #4 clk125MHz = ~clk125MHz;

    tx_segment_replay_buffer #(
        .BPP(BPP), .FRAME_PIXELS(FP), .ADDR_W(ADDR_W), .SEG_MAX(SEG_MAX),
        .PAYLOAD_START(PS), .PAYLOAD_BYTES(PB), .VRAM_LAT(VL)
    ) dut (
        .clk125MHz         (clk125MHz),
        .rst               (rst),
        .txid              (txid),
        .segment_num       (segment_num),
        .redundancy        (redundancy),
        .segment_num_max   (segment_num_max),
        .byte_data_counter (byte_data_counter),
        .vram_addr         (vram_addr),
        .vram_rdata        (vram_rdata),
        .doutb             (doutb),
        .startaddr         (startaddr),
        .oneframe_done     (oneframe_done),
        .maxdetect         (maxdetect),
        .seg_miss          (seg_miss),
        .seg_err           (seg_err)
    );

    function automatic logic [23:0] pix(input int a);
        return {8'(a) ^ seed, 8'(a >> 8) + seed, ~8'(a)};
    endfunction

    always @(posedge clk125MHz) begin
        vq[0] <= pix(int'(vram_addr));
        for (int i = 1; i < VL; i++)
            vq[i] <= vq[i-1];
    end
    assign vram_rdata = vq[VL-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_start = 0; m_fo = 0; m_err = 0; m_valid = '0;
    endtask

    task automatic send_pkt(input int tid, input int seg, input bit chk_md, input string tag);
        logic [7:0]  exp_b [PB];
        logic [23:0] px;
        int exp_miss, exp_done, nbad, nnz, nmiss, ndone;
        bit md_exp, md_seen;
        exp_miss = 0; exp_done = 0; nbad = 0; nnz = 0; nmiss = 0; ndone = 0;
        md_exp = 0; md_seen = 0;
        for (int i = 0; i < PB; i++) exp_b[i] = 8'd0;
        if (seg >= SEG_MAX) begin
            m_err = 1;
        end else if (tid == 1) begin
            m_valid[seg] = 0;
            m_start = m_ptr;
            m_start_tab[seg] = m_ptr;
            for (int p = 0; p < NP; p++) begin
                px = pix(m_ptr);
                for (int b = 0; b < BPP; b++)
                    exp_b[p*BPP+b] = 8'(px >> (8 * (BPP - 1 - b)));
                if (m_ptr == FP - 1) begin
                    md_exp = 1;
                    m_ptr = 0;
                    if (redundancy == 8'd1) begin
                        exp_done++; m_valid = '0; m_fo = 0;
                    end else m_fo = 1;
                end else m_ptr++;
            end
            for (int i = 0; i < PB; i++) m_store[seg][i] = exp_b[i];
            m_valid[seg] = 1;
        end else if (m_valid[seg]) begin
            for (int i = 0; i < PB; i++) exp_b[i] = m_store[seg][i];
            m_start = m_start_tab[seg];
            if (m_fo && tid == int'(redundancy) && seg == int'(segment_num_max) - 1) begin
                exp_done++; m_valid = '0; m_fo = 0; m_ptr = 0;
            end
        end else begin
            exp_miss = 1;
        end

        txid = 8'(tid);
        segment_num = 16'(seg);
        for (int c = 0; c < PKT_LEN; c++) begin
            byte_data_counter = 12'(c);
            @(posedge clk125MHz); #1;
            if (c >= PS && c < PS + PB) begin
                if (doutb !== exp_b[c-PS]) nbad++;
            end else if (doutb !== 8'd0) nnz++;
            nmiss += int'(seg_miss);
            ndone += int'(oneframe_done);
            if (maxdetect) md_seen = 1;
        end
        chk({tag, ".bytes_bad"}, nbad, 0);
        chk({tag, ".outside_nonzero"}, nnz, 0);
        chk({tag, ".seg_miss"}, nmiss, exp_miss);
        chk({tag, ".oneframe_done"}, ndone, exp_done);
        chk({tag, ".startaddr"}, startaddr, m_start);
        chk({tag, ".vram_addr"}, vram_addr, m_ptr);
        chk({tag, ".seg_err"}, seg_err, m_err);
        if (chk_md) chk({tag, ".maxdetect"}, md_seen, md_exp);
    endtask

    initial begin
        logic [23:0] px;
        int red, smax, seg, tid;
        rst = 1'b1; txid = 8'd1; segment_num = '0; redundancy = 8'd3;
        segment_num_max = 16'd3; byte_data_counter = 12'hFFF;
        seed = 8'($urandom);
        model_reset();
        repeat (3) @(posedge clk125MHz);
        #1;
        chk("reset.doutb", doutb, 0);
        chk("reset.vram_addr", vram_addr, 0);
        chk("reset.startaddr", startaddr, 0);
        chk("reset.flags", {oneframe_done, maxdetect, seg_miss, seg_err}, 0);
        rst = 1'b0;
        @(posedge clk125MHz); #1;

        send_pkt(1, 0, 0, "first_seg0");
        send_pkt(1, 4, 0, "seg4_copy1");
        send_pkt(2, 4, 0, "seg4_copy2");
        send_pkt(3, 4, 0, "seg4_copy3");
        send_pkt(2, 7, 0, "never_fetched");
        send_pkt(1, 8, 0, "seg8_fetch");
        send_pkt(1, 200, 0, "seg_too_big");
        send_pkt(2, 8, 0, "seg8_after_err");

        // Abandon a fetch at payload byte 100 via reset.
        txid = 8'd1; segment_num = 16'd5;
        for (int c = 0; c <= PS + 100; c++) begin
            byte_data_counter = 12'(c);
            @(posedge clk125MHz); #1;
        end
        px = pix((m_ptr + 100 / BPP) % FP);
        chk("abort.byte100", doutb, 8'(px >> 8));
        rst = 1'b1;
        byte_data_counter = 12'(PS + 101);
        @(posedge clk125MHz); #1;
        chk("abort.doutb", doutb, 0);
        chk("abort.vram_addr", vram_addr, 0);
        chk("abort.startaddr", startaddr, 0);
        chk("abort.seg_err", seg_err, 0);
        rst = 1'b0;
        byte_data_counter = 12'hFFF;
        model_reset();
        @(posedge clk125MHz); #1;
        send_pkt(2, 5, 0, "replay_after_abort");

        // Full frame: wrap lands inside segment 2.
        redundancy = 8'd2; segment_num_max = 16'd3;
        for (int s = 0; s < 3; s++) begin
            send_pkt(1, s, 1, $sformatf("frame_s%0d_t1", s));
            send_pkt(2, s, 1, $sformatf("frame_s%0d_t2", s));
        end
        send_pkt(2, 0, 0, "frame_cleared");

        red = $urandom_range(1, 3);
        smax = $urandom_range(1, 4);
        redundancy = 8'(red);
        segment_num_max = 16'(smax);
        for (int i = 0; i < 10; i++) begin
            seg = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            tid = $urandom_range(1, red);
            send_pkt(tid, seg, 0, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
